fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: RAM entry count; power of two, at least 4.
REQ-002 SHALL have parameter AF_MARGIN, default 2: almost-full margin in entries; range 1..DEPTH-1.
REQ-003 SHALL define AW = clog2(DEPTH), and pointers SHALL be AW+1 bits.
REQ-004 SHALL have port wr_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port wr_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port wr_req, input, 1 bit: push request from the producer.
REQ-007 SHALL have port rd_ptr_gray, input, AW+1 bits: Gray read pointer from the read clock domain; asynchronous to wr_clk.
REQ-008 SHALL have port wr_en, output, 1 bit: write strobe to the dual-port RAM.
REQ-009 SHALL have port wr_addr, output, AW bits: RAM write address.
REQ-010 SHALL have port wr_ptr_gray, output, AW+1 bits: registered Gray write pointer to the read domain.
REQ-011 SHALL have port wr_full, output, 1 bit: FIFO full, registered.
REQ-012 SHALL have port wr_almost_full, output, 1 bit: fill level is at least DEPTH-AF_MARGIN, registered.
REQ-013 SHALL have port wr_count, output, AW+1 bits: fill level as seen by the write domain, registered, range 0..DEPTH.
REQ-014 SHALL have port wr_overflow, output, 1 bit: one-cycle pulse marking a dropped push.

Function
REQ-015 SHALL drive wr_en = wr_req AND NOT wr_full, combinationally.
REQ-016 SHALL hold a binary write pointer wbin that increments by 1 on each wr_clk edge where wr_en=1, and holds otherwise.
REQ-017 SHALL let wbin wrap modulo 2^(AW+1) with no special handling.
REQ-018 SHALL drive wr_addr = wbin[AW-1:0] combinationally, so the RAM captures wr_data at wr_addr on the same edge.
REQ-019 SHALL compute wnext = wbin + wr_en, and SHALL register wr_ptr_gray <= wnext XOR (wnext >> 1), so exactly one bit changes per push.
REQ-020 SHALL pass rd_ptr_gray through a 2-flop synchronizer (s1, s2), and no logic SHALL read s1 or the raw input.
REQ-021 SHALL convert s2 Gray-to-binary to give rbin_s.
REQ-022 SHALL register wr_full <= (gray(wnext) == {~s2[AW:AW-1], s2[AW-2:0]}).
REQ-023 SHALL register wr_count <= wnext - rbin_s, computed modulo 2^(AW+1).
REQ-024 SHALL register wr_almost_full <= (wnext - rbin_s) >= DEPTH-AF_MARGIN.
REQ-025 SHALL assert wr_full on the same edge that accepts the DEPTH-th unread entry, so no overwrite ever occurs.
REQ-026 SHALL, on wr_req=1 while wr_full=1, not write, hold wbin, and set wr_overflow=1 for exactly the following cycle.
REQ-027 SHALL, when rd_ptr_gray changes and is stable before edge N, update wr_full, wr_count and wr_almost_full at edge N+2 (3rd edge).
REQ-028 SHALL, when a push and a read-pointer update arrive in the same cycle, compute flags from wnext and s2 as they stand at that edge, with no lost or double count.
REQ-029 SHALL treat an empty FIFO as needing no special case: wr_count=0, wr_full=0.

Reset
REQ-030 SHALL, on wr_rst_n=0 and immediately without waiting for a clock, clear wbin, wr_ptr_gray, s1, s2, wr_full, wr_almost_full, wr_count and wr_overflow to 0.
REQ-031 SHALL hold wr_en=0 and wr_addr=0 while in reset.
REQ-032 SHALL, on reset asserted mid-stream, discard all in-flight pointer and flag state, and the first push after release SHALL target address 0.
REQ-033 SHALL have reset release synchronized to wr_clk externally, and this block SHALL add no reset synchronizer.

Configuration
REQ-034 SHALL, when macro FIFO_WR_CTRL_ALMOST_FULL_EN is defined, implement wr_almost_full per REQ-024.
REQ-035 SHALL, when FIFO_WR_CTRL_ALMOST_FULL_EN is undefined, tie wr_almost_full to 0, remove its register and comparator, and ignore AF_MARGIN; the port SHALL remain present.

Verification
REQ-036 SHALL cover reset: assert wr_rst_n=0 mid-clock -> all outputs 0 before the next edge; first push after release -> wr_addr=0.
REQ-037 SHALL cover fill with DEPTH=16, rd_ptr_gray=0, and 16 consecutive wr_req -> wr_addr 0..15, wr_ptr_gray 1,3,2,6,...; wr_full=1 and wr_count=16 after the 16th edge; wr_almost_full=1 after the 14th edge.
REQ-038 SHALL cover overflow: when full, wr_req=1 for 2 cycles -> wr_en=0, wbin unchanged, wr_overflow high 2 cycles, then low.
REQ-039 SHALL cover drain: when full, set rd_ptr_gray=5'b00001 -> wr_full=0 and wr_count=15 exactly at the 3rd edge, not earlier.
REQ-040 SHALL cover wrap: 40 pushes interleaved with reader advances -> wbin passes 31->0, wr_ptr_gray returns to 0 after 32 pushes, and the full compare stays correct across the MSB flip.
REQ-041 SHALL cover configuration: build without FIFO_WR_CTRL_ALMOST_FULL_EN, repeat REQ-037 -> wr_almost_full stays 0 throughout and all other results are identical.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_wr_ctrl: write-side controller of an asynchronous FIFO; Gray pointer |
// | exchange, full/count/overflow flags. FIFO_WR_CTRL_ALMOST_FULL_EN adds     |
// | the registered almost-full flag.                                          |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fifo_wr_ctrl #(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          wr_clk,
    input  logic          wr_rst_n,
    input  logic          wr_req,
    input  logic [AW:0]   rd_ptr_gray,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW:0]   wr_ptr_gray,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic [AW:0]   wr_count,
    output logic          wr_overflow
);

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] r_wbin;
    logic [AW:0] r_wr_ptr_gray;
    logic [AW:0] r_sync1;
    logic [AW:0] r_sync2;
    logic [AW:0] r_count;
    logic        r_full;
    logic        r_overflow;

    logic        w_wr_en;
    logic [AW:0] w_wnext;
    logic [AW:0] w_wnext_gray;
    logic [AW:0] w_rbin_s;
    logic [AW:0] w_full_gray;
    logic [AW:0] w_level;

    // Qualifying with reset keeps the RAM strobe quiet while held in reset.
    assign w_wr_en      = wr_req & ~r_full & wr_rst_n;
    assign w_wnext      = r_wbin + {{AW{1'b0}}, w_wr_en};
    assign w_wnext_gray = w_wnext ^ (w_wnext >> 1);
    assign w_rbin_s     = gray2bin(r_sync2);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign w_full_gray  = {~r_sync2[AW:AW-1], r_sync2[AW-2:0]};
    assign w_level      = w_wnext - w_rbin_s;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_wbin        <= '0;
            r_wr_ptr_gray <= '0;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wnext;
            r_wr_ptr_gray <= w_wnext_gray;
            r_sync1       <= rd_ptr_gray;
            r_sync2       <= r_sync1;
            r_count       <= w_level;
            r_full        <= (w_wnext_gray == w_full_gray);
            r_overflow    <= wr_req & r_full;
        end
    end

`ifdef FIFO_WR_CTRL_ALMOST_FULL_EN
    localparam logic [AW:0] AF_LEVEL = (AW + 1)'(DEPTH - AF_MARGIN);

    logic r_almost_full;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level >= AF_LEVEL);
        end
    end

    assign wr_almost_full = r_almost_full;
`else
    logic w_unused_af_margin;
    assign w_unused_af_margin = (AF_MARGIN != 0);
    assign wr_almost_full     = 1'b0;
`endif

    assign wr_en       = w_wr_en;
    assign wr_addr     = r_wbin[AW-1:0];
    assign wr_ptr_gray = r_wr_ptr_gray;
    assign wr_full     = r_full;
    assign wr_count    = r_count;
    assign wr_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl (DEPTH=16).         |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_CTRL_ALMOST_FULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    typedef struct {
        logic       req;
        logic [4:0] rd;
        logic       en;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [4:0] rd;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       wr_full;
    logic       wr_almost_full;
    logic [4:0] wr_count;
    logic       wr_overflow;

    int checks   = 0;
    int failures = 0;

    fifo_wr_ctrl #(.DEPTH(16), .AF_MARGIN(2)) dut (
        .wr_clk         (clk),
        .wr_rst_n       (rst_n),
        .wr_req         (req),
        .rd_ptr_gray    (rd),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_ptr_gray    (wr_ptr_gray),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_count       (wr_count),
        .wr_overflow    (wr_overflow)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] g(input logic [4:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic vec_t mk(input logic rq, input logic [4:0] r, input logic e,
                                input logic [3:0] a, input logic [4:0] gr, input logic f,
                                input logic [4:0] c, input logic o);
        vec_t v;
        v.req = rq; v.rd = r; v.en = e; v.addr = a;
        v.gray = gr; v.full = f; v.cnt = c; v.ovf = o;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 0);
        chk({tag, ".wr_full"}, 32'(wr_full), 0);
        chk({tag, ".wr_almost_full"}, 32'(wr_almost_full), 0);
        chk({tag, ".wr_count"}, 32'(wr_count), 0);
        chk({tag, ".wr_overflow"}, 32'(wr_overflow), 0);
    endtask

    // One vector = one clock: combinational outputs before the edge, registers after.
    task automatic step(input vec_t v, input int idx);
        req = v.req;
        rd  = v.rd;
        #1;
        chk($sformatf("v%0d.wr_en", idx), 32'(wr_en), 32'(v.en));
        chk($sformatf("v%0d.wr_addr", idx), 32'(wr_addr), 32'(v.addr));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.wr_ptr_gray", idx), 32'(wr_ptr_gray), 32'(v.gray));
        chk($sformatf("v%0d.wr_full", idx), 32'(wr_full), 32'(v.full));
        chk($sformatf("v%0d.wr_count", idx), 32'(wr_count), 32'(v.cnt));
        chk($sformatf("v%0d.wr_almost_full", idx), 32'(wr_almost_full),
            32'(AF_ON && (v.cnt >= 5'd14)));
        chk($sformatf("v%0d.wr_overflow", idx), 32'(wr_overflow), 32'(v.ovf));
    endtask

    vec_t       tbl [23];
    logic [4:0] gseq [16];
    logic [4:0] wb;
    logic [4:0] rb;
    logic [4:0] diff;

    initial begin
        gseq = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};
        for (int k = 0; k < 16; k++) begin
            tbl[k] = mk(1'b1, 5'd0, 1'b1, 4'(k), gseq[k], (k == 15), 5'(k + 1), 1'b0);
        end
        // Overflow while full, then release of the request.
        tbl[16] = mk(1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b1);
        tbl[17] = mk(1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b1);
        tbl[18] = mk(1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b0);
        // Reader advances by one: visible only at the third edge.
        tbl[19] = mk(1'b0, 5'd1, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b0);
        tbl[20] = mk(1'b0, 5'd1, 1'b0, 4'd0, 5'd24, 1'b1, 5'd16, 1'b0);
        tbl[21] = mk(1'b0, 5'd1, 1'b0, 4'd0, 5'd24, 1'b0, 5'd15, 1'b0);
        tbl[22] = mk(1'b1, 5'd1, 1'b1, 4'd0, 5'd25, 1'b1, 5'd16, 1'b0);

        rst_n = 1'b0;
        req   = 1'b0;
        rd    = 5'd0;
        #2;
        chk_all_zero("reset");
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i], i);
        end

        // Reset asserted between edges with a request pending.
        #2;
        rst_n = 1'b0;
        req   = 1'b1;
        rd    = 5'd0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk_all_zero("midrst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.wr_en", 32'(wr_en), 1);
        chk("post_rst.wr_addr", 32'(wr_addr), 0);
        @(posedge clk);
        #1;
        chk("post_rst.wr_ptr_gray", 32'(wr_ptr_gray), 1);
        chk("post_rst.wr_count", 32'(wr_count), 1);

        // Wrap: 40 pushes, reader jumps by 4 whenever the FIFO is full.
        wb = 5'd1;
        rb = 5'd0;
        for (int i = 0; i < 40; i++) begin
            diff = wb - rb;
            if (diff == 5'd16) begin
                rb  = rb + 5'd4;
                rd  = g(rb);
                req = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                diff = wb - rb;
                chk($sformatf("wrap%0d.drain_count", i), 32'(wr_count), 32'(diff));
                chk($sformatf("wrap%0d.drain_full", i), 32'(wr_full), 0);
            end
            req = 1'b1;
            #1;
            chk($sformatf("wrap%0d.wr_en", i), 32'(wr_en), 1);
            chk($sformatf("wrap%0d.wr_addr", i), 32'(wr_addr), 32'(wb[3:0]));
            @(posedge clk);
            #1;
            wb   = wb + 5'd1;
            diff = wb - rb;
            chk($sformatf("wrap%0d.wr_ptr_gray", i), 32'(wr_ptr_gray), 32'(g(wb)));
            chk($sformatf("wrap%0d.wr_full", i), 32'(wr_full), 32'(diff == 5'd16));
            chk($sformatf("wrap%0d.wr_count", i), 32'(wr_count), 32'(diff));
            chk($sformatf("wrap%0d.wr_almost_full", i), 32'(wr_almost_full),
                32'(AF_ON && (diff >= 5'd14)));
        end
        req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
